multiplier_array_pipe: RTL and testbench

Parametrised, pipelined successor to the lane-parallel signed multiplier array in the sparse tensor-core datapath. It multiplies N_UNIT signed operand pairs per beat, with valid/ready flow control on both sides. It gates zero lanes using a per-lane sparsity mask and optionally accumulates into per-lane registers. Results are shifted and saturated to a configurable output width, and the block feeds the adder tree / accumulator buffer.

---
 rtl/multiplier_array_pipe.sv | 217 +++++++++++++++++++++
 tb/tb_multiplier_array_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_array_pipe.sv
// Pipelined lane-parallel signed multiplier array with sparsity gating and saturating accumulate.
// Optional MULT_ARRAY_SAT_FLAG_EN adds the per-lane out_sat saturation flag output.
module multiplier_array_pipe #(
    parameter int N_UNIT  = 32,
    parameter int DW_DATA = 8,
    parameter int DW_OUT  = 16,
    parameter int N_STAGE = 2,
    parameter int SHIFT   = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_UNIT*DW_DATA-1:0]  in_a,
    input  logic [N_UNIT*DW_DATA-1:0]  in_b,
    input  logic [N_UNIT-1:0]          in_mask,
    input  logic                       in_acc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_UNIT*DW_OUT-1:0]   out,
    output logic [N_UNIT-1:0]          out_mask
`ifdef MULT_ARRAY_SAT_FLAG_EN
    ,
    output logic [N_UNIT-1:0]          out_sat
`endif
);

    localparam int PW = 2 * DW_DATA;
    localparam int SW = DW_OUT + PW;
    localparam logic signed [SW-1:0] SAT_HI =
        {{(PW + 1){1'b0}}, {(DW_OUT - 1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_LO =
        {{(PW + 1){1'b1}}, {(DW_OUT - 1){1'b0}}};

    logic stall;
    logic adv;
    logic take;

    assign stall    = out_valid && !out_ready;
    assign adv      = !stall;
    assign in_ready = adv;
    assign take     = in_valid && adv;

    logic                 fin_v;
    logic                 fin_acc;
    logic [N_UNIT-1:0]    fin_mask;
    logic [N_UNIT*PW-1:0] fin_q;

    // Masked lanes yield a zero product regardless of operand contents.
    function automatic logic [PW-1:0] lane_q(
        input logic [DW_DATA-1:0] a,
        input logic [DW_DATA-1:0] b,
        input logic               en
    );
        logic signed [PW-1:0] ae;
        logic signed [PW-1:0] be;
        logic signed [PW-1:0] p;
        ae = {{DW_DATA{a[DW_DATA-1]}}, a};
        be = {{DW_DATA{b[DW_DATA-1]}}, b};
        p  = ae * be;
        lane_q = en ? p >>> SHIFT : '0;
    endfunction

    generate
        if (N_STAGE == 1) begin : g_direct
            always_comb begin
                fin_q = '0;
                for (int i = 0; i < N_UNIT; i++) begin
                    fin_q[i*PW +: PW] = lane_q(in_a[i*DW_DATA +: DW_DATA],
                                               in_b[i*DW_DATA +: DW_DATA],
                                               in_mask[i]);
                end
            end
            assign fin_v    = take;
            assign fin_acc  = in_acc;
            assign fin_mask = in_mask;
        end else begin : g_piped
            logic                      s1_v;
            logic                      s1_acc;
            logic [N_UNIT-1:0]         s1_mask;
            logic [N_UNIT*DW_DATA-1:0] s1_a;
            logic [N_UNIT*DW_DATA-1:0] s1_b;
            logic [N_UNIT*PW-1:0]      s1_q;

            // Inactive lanes keep their operand registers to avoid toggling.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    s1_v    <= 1'b0;
                    s1_acc  <= 1'b0;
                    s1_mask <= '0;
                    s1_a    <= '0;
                    s1_b    <= '0;
                end else if (adv) begin
                    s1_v <= take;
                    if (take) begin
                        s1_acc  <= in_acc;
                        s1_mask <= in_mask;
                        for (int i = 0; i < N_UNIT; i++) begin
                            if (in_mask[i]) begin
                                s1_a[i*DW_DATA +: DW_DATA] <= in_a[i*DW_DATA +: DW_DATA];
                                s1_b[i*DW_DATA +: DW_DATA] <= in_b[i*DW_DATA +: DW_DATA];
                            end
                        end
                    end
                end
            end

            always_comb begin
                s1_q = '0;
                for (int i = 0; i < N_UNIT; i++) begin
                    s1_q[i*PW +: PW] = lane_q(s1_a[i*DW_DATA +: DW_DATA],
                                              s1_b[i*DW_DATA +: DW_DATA],
                                              s1_mask[i]);
                end
            end

            if (N_STAGE == 2) begin : g_two
                assign fin_v    = s1_v;
                assign fin_acc  = s1_acc;
                assign fin_mask = s1_mask;
                assign fin_q    = s1_q;
            end else begin : g_deep
                localparam int ND = N_STAGE - 2;
                logic                 d_v    [ND];
                logic                 d_acc  [ND];
                logic [N_UNIT-1:0]    d_mask [ND];
                logic [N_UNIT*PW-1:0] d_q    [ND];

                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        for (int k = 0; k < ND; k++) begin
                            d_v[k]    <= 1'b0;
                            d_acc[k]  <= 1'b0;
                            d_mask[k] <= '0;
                            d_q[k]    <= '0;
                        end
                    end else if (adv) begin
                        d_v[0]    <= s1_v;
                        d_acc[0]  <= s1_acc;
                        d_mask[0] <= s1_mask;
                        d_q[0]    <= s1_q;
                        for (int k = 1; k < ND; k++) begin
                            d_v[k]    <= d_v[k-1];
                            d_acc[k]  <= d_acc[k-1];
                            d_mask[k] <= d_mask[k-1];
                            d_q[k]    <= d_q[k-1];
                        end
                    end
                end

                assign fin_v    = d_v[ND-1];
                assign fin_acc  = d_acc[ND-1];
                assign fin_mask = d_mask[ND-1];
                assign fin_q    = d_q[ND-1];
            end
        end
    endgenerate

    // The accumulators double as the output register: both always hold r.
    logic [N_UNIT*DW_OUT-1:0] acc;
    logic [N_UNIT*DW_OUT-1:0] r_vec;
`ifdef MULT_ARRAY_SAT_FLAG_EN
    logic [N_UNIT-1:0]        sat_vec;
`endif

    always_comb begin
        logic signed [SW-1:0] sum;
        logic [DW_OUT-1:0]    a_i;
        logic [PW-1:0]        q_i;
        r_vec = '0;
`ifdef MULT_ARRAY_SAT_FLAG_EN
        sat_vec = '0;
`endif
        for (int i = 0; i < N_UNIT; i++) begin
            a_i = acc[i*DW_OUT +: DW_OUT];
            q_i = fin_q[i*PW +: PW];
            sum = fin_acc ? {{PW{a_i[DW_OUT-1]}}, a_i} : '0;
            sum = sum + {{DW_OUT{q_i[PW-1]}}, q_i};
            if (sum > SAT_HI) begin
                r_vec[i*DW_OUT +: DW_OUT] = SAT_HI[DW_OUT-1:0];
`ifdef MULT_ARRAY_SAT_FLAG_EN
                sat_vec[i] = 1'b1;
`endif
            end else if (sum < SAT_LO) begin
                r_vec[i*DW_OUT +: DW_OUT] = SAT_LO[DW_OUT-1:0];
`ifdef MULT_ARRAY_SAT_FLAG_EN
                sat_vec[i] = 1'b1;
`endif
            end else begin
                r_vec[i*DW_OUT +: DW_OUT] = sum[DW_OUT-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            acc       <= '0;
            out_mask  <= '0;
`ifdef MULT_ARRAY_SAT_FLAG_EN
            out_sat   <= '0;
`endif
        end else if (adv) begin
            out_valid <= fin_v;
            if (fin_v) begin
                acc      <= r_vec;
                out_mask <= fin_mask;
`ifdef MULT_ARRAY_SAT_FLAG_EN
                out_sat  <= sat_vec;
`endif
            end
        end
    end

    assign out = acc;

endmodule

// File: tb/tb_multiplier_array_pipe.sv
// Randomized scoreboard bench for multiplier_array_pipe against an arithmetic lane model.
// Honours MULT_ARRAY_SAT_FLAG_EN when the feature is compiled in.
module tb_multiplier_array_pipe;

    localparam int N_UNIT  = 32;
    localparam int DW_DATA = 8;
    localparam int DW_OUT  = 16;
    localparam int N_STAGE = 2;
    localparam int SHIFT   = 0;
    localparam int AW = N_UNIT * DW_DATA;
    localparam int OW = N_UNIT * DW_OUT;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [AW-1:0]     in_a;
    logic [AW-1:0]     in_b;
    logic [N_UNIT-1:0] in_mask;
    logic              in_acc;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     out;
    logic [N_UNIT-1:0] out_mask;
`ifdef MULT_ARRAY_SAT_FLAG_EN
    logic [N_UNIT-1:0] out_sat;
`endif

    multiplier_array_pipe #(
        .N_UNIT(N_UNIT), .DW_DATA(DW_DATA), .DW_OUT(DW_OUT),
        .N_STAGE(N_STAGE), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mask(in_mask), .in_acc(in_acc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_mask(out_mask)
`ifdef MULT_ARRAY_SAT_FLAG_EN
        , .out_sat(out_sat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0]     o;
        logic [N_UNIT-1:0] m;
        logic [N_UNIT-1:0] s;
    } beat_t;

    beat_t exp_q[$];
    int    acc_m[N_UNIT];
    int    n_chk;
    int    n_pass;
    bit    took;

    task automatic chk(input string tag, input logic [OW-1:0] got,
                       input logic [OW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [OW-1:0] lv(input logic [DW_OUT-1:0] x);
        return OW'(x);
    endfunction

    function automatic logic [AW-1:0] rnd_ops();
        logic [AW-1:0] v;
        for (int i = 0; i < N_UNIT; i++) v[i*DW_DATA +: DW_DATA] = DW_DATA'($urandom);
        return v;
    endfunction

    // Lane arithmetic straight from the rules: product, floor shift, clamp.
    task automatic model_accept();
        beat_t e;
        int hi, lo, av, bv, q, s, r;
        hi = (1 << (DW_OUT - 1)) - 1;
        lo = -(1 << (DW_OUT - 1));
        e.o = '0;
        e.s = '0;
        e.m = in_mask;
        for (int i = 0; i < N_UNIT; i++) begin
            av = $signed(in_a[i*DW_DATA +: DW_DATA]);
            bv = $signed(in_b[i*DW_DATA +: DW_DATA]);
            q = in_mask[i] ? ((av * bv) >>> SHIFT) : 0;
            s = in_acc ? acc_m[i] + q : q;
            r = s > hi ? hi : (s < lo ? lo : s);
            e.s[i] = (r != s);
            acc_m[i] = r;
            e.o[i*DW_OUT +: DW_OUT] = DW_OUT'(r);
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic v, input logic [AW-1:0] a,
                        input logic [AW-1:0] b, input logic [N_UNIT-1:0] m,
                        input logic ac, input logic rdy);
        beat_t e;
        @(negedge clk);
        in_valid = v; in_a = a; in_b = b;
        in_mask = m; in_acc = ac; out_ready = rdy;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_beat", OW'(1), OW'(0));
            end else begin
                e = exp_q.pop_front();
                chk("out", out, e.o);
                chk("out_mask", OW'(out_mask), OW'(e.m));
`ifdef MULT_ARRAY_SAT_FLAG_EN
                chk("out_sat", OW'(out_sat), OW'(e.s));
`endif
            end
        end
        chk("in_ready", OW'(in_ready), OW'(!(out_valid && !out_ready)));
        took = in_valid && in_ready;
        if (took) model_accept();
    endtask

    task automatic idle();
        step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 50) begin
            idle();
            k++;
        end
        chk("drain", OW'(exp_q.size()), OW'(0));
    endtask

    initial begin
        logic [AW-1:0] a, b;
        int n, sent, g;
        n_chk = 0; n_pass = 0; took = 0;
        for (int i = 0; i < N_UNIT; i++) acc_m[i] = 0;
        reset = 1'b0; in_valid = 0; in_a = '0; in_b = '0;
        in_mask = '0; in_acc = 0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_out_valid", OW'(out_valid), OW'(0));
        chk("rst_out", out, '0);
        chk("rst_out_mask", OW'(out_mask), OW'(0));
        chk("rst_in_ready", OW'(in_ready), OW'(1));

        a = '0; b = '0;
        a[7:0] = 8'd3; b[7:0] = 8'hfc;
        step(1'b1, a, b, '1, 1'b0, 1'b1);
        n = 0;
        do begin idle(); n++; end while (!out_valid && n < 10);
        chk("latency", OW'(n), OW'(N_STAGE));
        chk("lane0_neg12", lv(out[DW_OUT-1:0]), lv(DW_OUT'(-12)));
        idle();
        chk("pulse_width", OW'(out_valid), OW'(0));

        a = '0; b = '0;
        a[7:0] = 8'h80; b[7:0] = 8'h80;
        step(1'b1, a, b, '1, 1'b0, 1'b1);
        drain();
        chk("lane0_16384", lv(out[DW_OUT-1:0]), lv(DW_OUT'(16384)));
        repeat (3) step(1'b1, a, b, '1, 1'b1, 1'b1);
        drain();
        chk("lane0_sat", lv(out[DW_OUT-1:0]), lv(DW_OUT'(32767)));
`ifdef MULT_ARRAY_SAT_FLAG_EN
        chk("lane0_sat_flag", OW'(out_sat[0]), OW'(1));
`endif

        a = '0; b = '0;
        a[5*DW_DATA +: DW_DATA] = 8'd4; b[5*DW_DATA +: DW_DATA] = 8'd5;
        step(1'b1, a, b, '1, 1'b0, 1'b1);
        a[5*DW_DATA +: DW_DATA] = 8'd9; b[5*DW_DATA +: DW_DATA] = 8'd9;
        step(1'b1, a, b, ~(N_UNIT'(1) << 5), 1'b1, 1'b1);
        drain();
        chk("lane5_hold", lv(out[5*DW_OUT +: DW_OUT]), lv(DW_OUT'(20)));
        chk("lane5_mask", OW'(out_mask[5]), OW'(0));

        sent = 0; g = 0;
        while (sent < 8 && g < 40) begin
            step(1'b1, rnd_ops(), rnd_ops(), N_UNIT'($urandom),
                 1'($urandom), !(g >= 3 && g < 6));
            if (took) sent++;
            g++;
        end
        chk("stream_sent", OW'(sent), OW'(8));
        drain();

        a = '0; b = '0;
        a[7:0] = 8'd5; b[7:0] = 8'd10;
        step(1'b1, a, b, '1, 1'b0, 1'b1);
        drain();
        step(1'b1, rnd_ops(), rnd_ops(), '1, 1'b1, 1'b1);
        step(1'b1, rnd_ops(), rnd_ops(), '1, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("midrst_valid", OW'(out_valid), OW'(0));
        chk("midrst_out", out, '0);
        exp_q.delete();
        for (int i = 0; i < N_UNIT; i++) acc_m[i] = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        a = '0; b = '0;
        a[7:0] = 8'd2; b[7:0] = 8'd3;
        step(1'b1, a, b, '1, 1'b1, 1'b1);
        drain();
        chk("post_rst_acc", lv(out[DW_OUT-1:0]), lv(DW_OUT'(6)));

        for (int c = 0; c < 300; c++) begin
            step($urandom_range(0, 3) != 0, rnd_ops(), rnd_ops(),
                 N_UNIT'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
